// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle ALU.
//   alu_op_e    - 4-bit opcode encoding seen on ALUControl
//   alu_state_e - control FSM states
//   is_long_op  - true for opcodes handled by the iterative mul/div datapath
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OpNop   = 4'h0,
    OpAdd   = 4'h1,
    OpSub   = 4'h2,
    OpSlt   = 4'h3,
    OpAnd   = 4'h4,
    OpOr    = 4'h5,
    OpXor   = 4'h6,
    OpNor   = 4'h7,
    OpSll   = 4'h8,
    OpSrl   = 4'h9,
    OpSra   = 4'hA,
    OpSltu  = 4'hB,
    OpMul   = 4'hC,
    OpMulhu = 4'hD,
    OpDivu  = 4'hE,
    OpRemu  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // MUL/MULHU/DIVU/REMU all share the 2'b11 prefix.
  function automatic logic is_long_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative unsigned multiplier / restoring divider, one step per cycle.
//   clk_i, rst_i    - clock, synchronous active-high reset
//   start_i         - load operands (a_i = multiplier/dividend, b_i = multiplicand/divisor)
//   div_i           - captured with start_i: 1 = divide, 0 = multiply
//   step_i          - perform one iteration
//   done_o          - this step is the last (WIDTH-th) one
//   hi_o, lo_o      - next accumulator value: {product hi, lo} or {remainder, quotient}
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             step_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic             div_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_cin;

  always_comb begin
    // One shared WIDTH+1 bit adder: accumulate for multiply, trial-subtract for divide.
    if (div_q) begin
      add_a   = {hi_q, lo_q[WIDTH-1]};
      add_b   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, b_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (start_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // Remainder stays below the divisor, so add_sum[WIDTH] is the borrow.
        hi_d = add_sum[WIDTH] ? add_a[WIDTH-1:0] : add_sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
      end else begin
        {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      if (start_i) begin
        b_q   <= b_i;
        div_q <= div_i;
      end
    end
  end

  assign done_o = step_i && (cnt_q == CntW'(WIDTH - 1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - request handshake; DR1/DR2/ALUControl captured on acceptance
//   DR1, DR2            - operands (shift amount = DR2[log2(WIDTH)-1:0])
//   ALUControl          - opcode (alu_op_e)
//   out_valid           - one-cycle result pulse
//   ALUOutput, zero, overflow, div_by_zero - registered result and flags
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] DR1,
  input  logic [WIDTH-1:0] DR2,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUOutput,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_e       state_q;
  alu_op_e          op_q;
  logic             div0_q;
  logic             out_valid_q, zero_q, ovf_q, dbz_q;
  logic [WIDTH-1:0] result_q;

  alu_op_e          op_in;
  logic             accept, start_long, run_div0, md_step, md_done, sc_ovf;
  logic [WIDTH-1:0] sum, diff, sc_result, long_result, md_hi, md_lo;
  logic [ShW-1:0]   shamt;

  assign op_in      = alu_op_e'(ALUControl);
  assign in_ready   = (state_q != StRun);
  assign accept     = in_valid && in_ready;
  assign start_long = accept && is_long_op(ALUControl);
  // A divide by zero never iterates; its single RUN cycle just publishes the fixed result.
  assign run_div0   = div0_q && (op_q inside {OpDivu, OpRemu});
  assign md_step    = (state_q == StRun) && !run_div0;

  alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start_long),
    .div_i  (ALUControl[1]),
    .a_i    (DR1),
    .b_i    (DR2),
    .step_i (md_step),
    .done_o (md_done),
    .hi_o   (md_hi),
    .lo_o   (md_lo)
  );

  always_comb begin
    sum       = DR1 + DR2;
    diff      = DR1 - DR2;
    shamt     = DR2[ShW-1:0];
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op_in)
      OpAdd: begin
        sc_result = sum;
        sc_ovf    = (DR1[WIDTH-1] == DR2[WIDTH-1]) && (sum[WIDTH-1] != DR1[WIDTH-1]);
      end
      OpSub: begin
        sc_result = diff;
        sc_ovf    = (DR1[WIDTH-1] != DR2[WIDTH-1]) && (diff[WIDTH-1] != DR1[WIDTH-1]);
      end
      OpSlt:   sc_result = {{(WIDTH-1){1'b0}}, $signed(DR1) < $signed(DR2)};
      OpAnd:   sc_result = DR1 & DR2;
      OpOr:    sc_result = DR1 | DR2;
      OpXor:   sc_result = DR1 ^ DR2;
      OpNor:   sc_result = ~(DR1 | DR2);
      OpSll:   sc_result = DR1 << shamt;
      OpSrl:   sc_result = DR1 >> shamt;
      OpSra:   sc_result = $signed(DR1) >>> shamt;
      OpSltu:  sc_result = {{(WIDTH-1){1'b0}}, DR1 < DR2};
      default: sc_result = '0;
    endcase
  end

  always_comb begin
    long_result = md_lo;
    case (op_q)
      OpMulhu: long_result = md_hi;
      OpDivu:  long_result = div0_q ? '1 : md_lo;
      OpRemu:  long_result = div0_q ? md_lo : md_hi;  // md_lo still holds the dividend
      default: long_result = md_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (accept) begin
            op_q   <= op_in;
            div0_q <= (DR2 == '0);
            if (is_long_op(ALUControl)) begin
              state_q <= StRun;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= sc_result;
              zero_q      <= (sc_result == '0);
              ovf_q       <= sc_ovf;
              dbz_q       <= 1'b0;
            end
          end
        end
        StRun: begin
          if (run_div0 || md_done) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            result_q    <= long_result;
            zero_q      <= (long_result == '0);
            ovf_q       <= 1'b0;
            dbz_q       <= run_div0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign ALUOutput   = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, zero, overflow, div_by_zero;
  logic [31:0] DR1 = '0, DR2 = '0, ALUOutput;
  logic [3:0]  ALUControl = '0;
  logic        in_valid8 = 1'b0, in_ready8, out_valid8, zero8, overflow8, div_by_zero8;
  logic [7:0]  DR1_8 = '0, DR2_8 = '0, ALUOutput8;
  logic [3:0]  ALUControl8 = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .DR1(DR1), .DR2(DR2),
    .ALUControl(ALUControl), .out_valid(out_valid), .ALUOutput(ALUOutput), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .DR1(DR1_8),
    .DR2(DR2_8), .ALUControl(ALUControl8), .out_valid(out_valid8), .ALUOutput(ALUOutput8),
    .zero(zero8), .overflow(overflow8), .div_by_zero(div_by_zero8)
  );

  // Reference: plain integer arithmetic on zero-extended / sign-extended operands.
  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic ov, output logic dz);
    longint unsigned m, ua, ub, res;
    longint sa, sb, s, smax, smin;
    int sh;
    m    = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -smax - 1;
    sa   = ua[w-1] ? $signed(ua - m - 64'd1) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub - m - 64'd1) : $signed(ub);
    sh   = int'(ub % longint'(w));
    ov   = 1'b0;
    dz   = 1'b0;
    res  = 64'd0;
    case (op)
      4'h1: begin res = ua + ub; s = sa + sb; ov = (s > smax) || (s < smin); end
      4'h2: begin res = ua - ub; s = sa - sb; ov = (s > smax) || (s < smin); end
      4'h3: res = (sa < sb) ? 64'd1 : 64'd0;
      4'h4: res = ua & ub;
      4'h5: res = ua | ub;
      4'h6: res = ua ^ ub;
      4'h7: res = ~(ua | ub);
      4'h8: res = ua << sh;
      4'h9: res = ua >> sh;
      4'hA: res = $unsigned(sa >>> sh);
      4'hB: res = (ua < ub) ? 64'd1 : 64'd0;
      4'hC: res = ua * ub;
      4'hD: res = (ua * ub) >> w;
      4'hE: begin dz = (ub == 0); if (dz) res = m; else res = ua / ub; end
      4'hF: begin dz = (ub == 0); if (dz) res = ua; else res = ua % ub; end
      default: res = 64'd0;
    endcase
    res = res & m;
    r   = res[31:0];
  endfunction

  function automatic logic [4:0] obs_flags(input bit w8);
    if (w8) return {out_valid8, in_ready8, zero8, overflow8, div_by_zero8};
    return {out_valid, in_ready, zero, overflow, div_by_zero};
  endfunction

  function automatic logic [31:0] obs_res(input bit w8);
    return w8 ? {24'd0, ALUOutput8} : ALUOutput;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (w8) begin
      in_valid8 = v; ALUControl8 = op; DR1_8 = a[7:0]; DR2_8 = b[7:0];
    end else begin
      in_valid = v; ALUControl = op; DR1 = a; DR2 = b;
    end
  endtask

  // Issue one op, scramble inputs afterwards, check latency, busy ready, result and flags.
  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] got_r);
    logic [31:0] er, mask;
    logic        eo, ed, gv;
    logic [4:0]  f;
    int          w, lat, cyc;
    bit          seen;
    w    = w8 ? 8 : 32;
    mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
    model(w, op, a, b, er, eo, ed);
    if (op[3:2] != 2'b11) lat = 1;
    else if (op[1] && ((b & mask) == 32'd0)) lat = 2;
    else lat = w + 1;

    @(negedge clk);
    f = obs_flags(w8);
    total++;
    if (f[4] !== 1'b0 || f[3] !== 1'b1) begin
      bad++;
      $display("FAIL pre_issue w=%0d op=%h: valid/ready=%b%b, want 01", w, op, f[4], f[3]);
    end
    drive(w8, 1'b1, op, a, b);
    @(negedge clk);
    drive(w8, 1'b0, 4'($urandom), $urandom, $urandom);
    cyc  = 1;
    seen = 0;
    while (!seen && cyc <= w + 4) begin
      f = obs_flags(w8);
      if (f[4] === 1'b1) begin
        seen = 1;
      end else begin
        if (cyc < lat) begin
          total++;
          if (f[3] !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready w=%0d op=%h cyc=%0d: in_ready=%b, want 0", w, op, cyc, f[3]);
          end
        end
        // Requests while busy must be ignored.
        gv = (cyc < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(w8, gv, 4'($urandom), $urandom, $urandom);
        @(negedge clk);
        cyc++;
      end
    end
    drive(w8, 1'b0, 4'($urandom), $urandom, $urandom);
    got_r = obs_res(w8);
    total++;
    if (!seen || cyc != lat) begin
      bad++;
      $display("FAIL latency w=%0d op=%h a=%h b=%h: seen=%0d cyc=%0d, want %0d",
               w, op, a, b, seen, cyc, lat);
    end
    if (seen) begin
      total++;
      if (got_r !== er) begin
        bad++;
        $display("FAIL result w=%0d op=%h a=%h b=%h: got %h, want %h", w, op, a, b, got_r, er);
      end
      total++;
      if (f[3:0] !== {1'b1, er == 32'd0, eo, ed}) begin
        bad++;
        $display("FAIL flags w=%0d op=%h a=%h b=%h: ready/zero/ovf/dbz=%b, want %b",
                 w, op, a, b, f[3:0], {1'b1, er == 32'd0, eo, ed});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, in_ready, zero, overflow, div_by_zero} !== 5'b01000 || ALUOutput !== 32'd0) begin
      bad++;
      $display("FAIL reset32: flags=%b out=%h, want 01000 0", obs_flags(0), ALUOutput);
    end
    total++;
    if (obs_flags(1) !== 5'b01000 || ALUOutput8 !== 8'd0) begin
      bad++;
      $display("FAIL reset8: flags=%b out=%h, want 01000 0", obs_flags(1), ALUOutput8);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  ops[11] = '{4'h1, 4'h2, 4'h3, 4'hB, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF, 4'hE, 4'hF};
    logic [31:0] as[11]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] bs[11]  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd4, 32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0};
    logic [31:0] ex[11]  = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'hF800_0000, 32'hFFFF_FFFE,
                             32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] r;
    for (int i = 0; i < 11; i++) begin
      run_op(1'b0, ops[i], as[i], bs[i], r);
      total++;
      if (r !== ex[i]) begin
        bad++;
        $display("FAIL directed[%0d] op=%h: got %h, want %h", i, ops[i], r, ex[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    bit          stray;
    @(negedge clk);
    drive(1'b0, 1'b1, 4'hE, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, zero, overflow, div_by_zero} !== 5'b01000 || ALUOutput !== 32'd0) begin
      bad++;
      $display("FAIL abort_reset: flags=%b out=%h, want 01000 0", obs_flags(0), ALUOutput);
    end
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL abort_no_valid: out_valid seen=1, want 0");
    end
    run_op(1'b0, 4'h1, 32'd3, 32'd4, r);
    total++;
    if (r !== 32'd7) begin
      bad++;
      $display("FAIL abort_add: got %h, want 7", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pr, a, b, er;
    logic        po, eo, ed;
    logic [3:0]  op;
    pr = '0;
    po = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || ALUOutput !== pr || overflow !== po) begin
          bad++;
          $display("FAIL b2b[%0d]: v=%b rdy=%b out=%h ovf=%b, want 1 1 %h %b",
                   i, out_valid, in_ready, ALUOutput, overflow, pr, po);
        end
      end
      if (i < 12) begin
        op = 4'($urandom_range(0, 11));
        a  = $urandom;
        b  = $urandom;
        model(32, op, a, b, er, eo, ed);
        pr = er;
        po = eo;
        drive(1'b0, 1'b1, op, a, b);
      end else begin
        drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      end
    end
  endtask

  task automatic test_random(input bit w8, input int n);
    logic [31:0] a, b, r;
    logic [3:0]  op;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = w8 ? 32'h80 : 32'h8000_0000;
        2: b = a;
        3: a = $urandom_range(0, 15);
        default: ;
      endcase
      run_op(w8, op, a, b, r);
    end
  endtask

  task automatic test_width8();
    logic [31:0] r;
    run_op(1'b1, 4'hD, 32'hFF, 32'hFF, r);
    total++;
    if (r !== 32'hFE) begin
      bad++;
      $display("FAIL w8_mulhu: got %h, want fe", r);
    end
    run_op(1'b1, 4'hE, 32'hFF, 32'h10, r);
    total++;
    if (r !== 32'h0F) begin
      bad++;
      $display("FAIL w8_divu: got %h, want 0f", r);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random(1'b0, 150);
    test_width8();
    test_random(1'b1, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU. Single-cycle arithmetic, logic, compare and shift operations return a registered result one cycle after issue. Multiply and unsigned divide/remainder run on an iterative shared datapath over WIDTH cycles. Sits between the decode/register-read stage and writeback; a valid/ready handshake lets the pipeline stall on long operations.

## Interface
- WIDTH, 32, operand/result width (≥4, power of 2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- DR1  in  WIDTH  operand A
- DR2  in  WIDTH  operand B (shift amount = DR2[log2(WIDTH)-1:0])
- ALUControl  in  4  opcode
- out_valid  out  1  one-cycle pulse, result valid
- ALUOutput  out  WIDTH  result, held until next out_valid
- zero  out  1  ALUOutput == 0, valid with out_valid
- overflow  out  1  signed overflow, ADD/SUB only, else 0
- div_by_zero  out  1  DIVU/REMU with DR2 == 0, else 0

## Operation
- Opcodes: 0000 NOP (result 0); 0001 ADD; 0010 SUB; 0011 SLT (signed DR1<DR2 → 1/0); 0100 AND; 0101 OR; 0110 XOR; 0111 NOR; 1000 SLL; 1001 SRL; 1010 SRA; 1011 SLTU; 1100 MUL (low WIDTH bits); 1101 MULHU (high WIDTH bits, unsigned); 1110 DIVU; 1111 REMU.
- Accept on in_valid && in_ready; DR1, DR2 and ALUControl are captured at acceptance and may change afterwards.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. A single-cycle op writes its result and flags and pulses out_valid next cycle; state remains IDLE. MUL/MULHU/DIVU/REMU → RUN, counter=0.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle; after WIDTH steps → DONE.
  - DONE: result and flags registered, out_valid=1, in_ready=1, → IDLE; a request accepted in DONE is handled as if in IDLE.
- Multiply: 2·WIDTH-bit unsigned product; MUL takes the low half, MULHU the high half.
- Divide by zero: the iteration is skipped and the block goes straight to DONE; DIVU result = all ones, REMU result = DR1, div_by_zero=1.
- Flags: zero is computed on every result. overflow = (A and B same sign for ADD / differing sign for SUB) and result sign ≠ A sign.

## Timing
- Reset: in_ready=1, out_valid=0, ALUOutput=0, zero=0, overflow=0, div_by_zero=0, state=IDLE, counter=0.
- Single-cycle ops: latency 1, throughput 1 per cycle; back-to-back issue is supported.
- MUL/MULHU/DIVU/REMU: out_valid WIDTH+1 cycles after acceptance; in_ready=0 from the cycle after acceptance until DONE.
- Divide by zero: latency 2 (accept → DONE → out_valid).
- rst during RUN aborts the operation: no out_valid, all outputs return to reset values next cycle.
- in_valid while in_ready=0 is ignored; the requester must hold the request.

## Structure
- Package alu_mc_pkg: 4-bit opcode localparams/enum, FSM state enum.
- Sub-module alu_muldiv: iterative shift-add multiplier and restoring divider sharing one WIDTH+1-bit adder, one accumulator register and the step counter. Start/done interface, driven by the alu_mc FSM.
- Single-cycle combinational ops and flag logic stay in alu_mc.

## Test plan
- ADD 0x7FFF_FFFF+0x1 → 0x8000_0000, overflow=1, zero=0, 1 cycle; SUB 5−5 → 0, zero=1, overflow=0.
- SLT 0xFFFF_FFFF,0x1 → 1; SLTU same operands → 0; SRA 0x8000_0000 by 4 → 0xF800_0000; back-to-back issue on consecutive cycles, each result one cycle later.
- MUL 0xFFFF_FFFF×2 → 0xFFFF_FFFE; MULHU same → 0x1; out_valid at cycle 33 after acceptance, in_ready=0 in cycles 1-32.
- DIVU 100/7 → 14, REMU 100/7 → 2; DIVU 5/0 → 0xFFFF_FFFF with div_by_zero=1 at cycle 2; REMU 5/0 → 5.
- rst asserted at cycle 10 of a DIVU → no out_valid, all outputs at reset values; a following ADD 3+4 → 7 completes normally.
- WIDTH=8: MULHU 0xFF×0xFF → 0xFE, DIVU 0xFF/0x10 → 0x0F, out_valid at cycle 9.
